// File: rtl/instr_encoder_if.sv
// Request and imem-write handshake bundle for the RV32I instruction encoder.
// The master side issues field-level requests and consumes encoded words;
// the slave side is the encoder itself.
interface instr_encoder_if #(
    parameter int ADDR_W = 10
);
    logic              req_valid;
    logic              req_ready;
    logic [3:0]        req_op;
    logic [4:0]        req_rd;
    logic [4:0]        req_rs1;
    logic [4:0]        req_rs2;
    logic [20:0]       req_imm;

    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;

    modport master (
        output req_valid, req_op, req_rd, req_rs1, req_rs2, req_imm,
        input  req_ready,
        input  wr_valid, wr_addr, wr_data,
        output wr_ready
    );

    modport slave (
        input  req_valid, req_op, req_rd, req_rs1, req_rs2, req_imm,
        output req_ready,
        output wr_valid, wr_addr, wr_data,
        input  wr_ready
    );
endinterface

// File: rtl/instr_encoder.sv
// Sequential RV32I instruction encoder: packs field-level requests into
// 32-bit machine words and streams them into instruction memory at
// auto-incrementing word addresses. A one-entry output register decouples
// request acceptance from the imem write handshake.
module instr_encoder #(
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    instr_encoder_if.slave    bus,
    output logic [ADDR_W-2:0] word_cnt,
    output logic              full,
    output logic              err,
    output logic [1:0]        err_code
);
    localparam int CNT_W = ADDR_W - 1;
    localparam logic [CNT_W-1:0]  DEPTH_CNT  = CNT_W'(DEPTH);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);
    localparam logic [ADDR_W-1:0] WORD_STEP  = ADDR_W'(4);

    localparam logic [3:0] OP_LW   = 4'd0;
    localparam logic [3:0] OP_ADDI = 4'd1;
    localparam logic [3:0] OP_ORI  = 4'd2;
    localparam logic [3:0] OP_ANDI = 4'd3;
    localparam logic [3:0] OP_ADD  = 4'd4;
    localparam logic [3:0] OP_SUB  = 4'd5;
    localparam logic [3:0] OP_OR   = 4'd6;
    localparam logic [3:0] OP_AND  = 4'd7;
    localparam logic [3:0] OP_SLT  = 4'd8;
    localparam logic [3:0] OP_SW   = 4'd9;
    localparam logic [3:0] OP_BEQ  = 4'd10;
    localparam logic [3:0] OP_BNE  = 4'd11;
    localparam logic [3:0] OP_JAL  = 4'd12;
    localparam logic [3:0] OP_JALR = 4'd13;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    typedef enum logic {
        ST_EMPTY,
        ST_HOLD
    } state_e;

    state_e            state;
    state_e            state_next;
    logic [ADDR_W-1:0] ptr;
    logic [31:0]       data_q;

    logic [31:0] enc_word;
    logic        illegal;
    logic        range_bad;
    logic        align_bad;
    logic [1:0]  code_new;
    logic        req_ok;
    logic        accept;
    logic        wr_fire;
    logic        i_fits;
    logic        b_fits;

    logic [20:0] imm;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;

    assign imm = bus.req_imm;
    assign rd  = bus.req_rd;
    assign rs1 = bus.req_rs1;
    assign rs2 = bus.req_rs2;

    // 12-bit signed fits when the upper bits are pure sign extension;
    // branch offsets additionally exclude +4095 so the top of range is +4094.
    assign i_fits = (&imm[20:11]) | ~(|imm[20:11]);
    assign b_fits = ((&imm[20:12]) | ~(|imm[20:12])) && (imm != 21'd4095);

    assign bus.wr_valid  = (state == ST_HOLD);
    assign bus.wr_addr   = ptr;
    assign bus.wr_data   = data_q;
    assign full          = (word_cnt == DEPTH_CNT);
    assign bus.req_ready = rst_n && !full && (!bus.wr_valid || bus.wr_ready) && !start;

    assign accept  = bus.req_valid && bus.req_ready;
    assign wr_fire = bus.wr_valid && bus.wr_ready && !start;

    // Pack the request fields into the machine word and flag illegal/out-of-range/misaligned requests
    always_comb begin
        enc_word  = 32'd0;
        illegal   = 1'b0;
        range_bad = 1'b0;
        align_bad = 1'b0;
        case (bus.req_op)
            OP_LW: begin
                enc_word  = {imm[11:0], rs1, 3'b010, rd, OPC_LOAD};
                range_bad = !i_fits;
            end
            OP_ADDI: begin
                enc_word  = {imm[11:0], rs1, 3'b000, rd, OPC_OPIMM};
                range_bad = !i_fits;
            end
            OP_ORI: begin
                enc_word  = {imm[11:0], rs1, 3'b110, rd, OPC_OPIMM};
                range_bad = !i_fits;
            end
            OP_ANDI: begin
                enc_word  = {imm[11:0], rs1, 3'b111, rd, OPC_OPIMM};
                range_bad = !i_fits;
            end
            OP_ADD:  enc_word = {7'b0000000, rs2, rs1, 3'b000, rd, OPC_OP};
            OP_SUB:  enc_word = {7'b0100000, rs2, rs1, 3'b000, rd, OPC_OP};
            OP_OR:   enc_word = {7'b0000000, rs2, rs1, 3'b110, rd, OPC_OP};
            OP_AND:  enc_word = {7'b0000000, rs2, rs1, 3'b111, rd, OPC_OP};
            OP_SLT:  enc_word = {7'b0000000, rs2, rs1, 3'b010, rd, OPC_OP};
            OP_SW: begin
                enc_word  = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], OPC_STORE};
                range_bad = !i_fits;
            end
            OP_BEQ: begin
                enc_word  = {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], OPC_BRANCH};
                range_bad = !b_fits;
                align_bad = imm[0];
            end
            OP_BNE: begin
                enc_word  = {imm[12], imm[10:5], rs2, rs1, 3'b001, imm[4:1], imm[11], OPC_BRANCH};
                range_bad = !b_fits;
                align_bad = imm[0];
            end
            OP_JAL: begin
                enc_word  = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OPC_JAL};
                align_bad = imm[0];
            end
            OP_JALR: begin
                enc_word  = {imm[11:0], rs1, 3'b000, rd, OPC_JALR};
                range_bad = !i_fits;
            end
            default: illegal = 1'b1;
        endcase
    end

    assign code_new = illegal   ? 2'd1 :
                      range_bad ? 2'd2 :
                      align_bad ? 2'd3 : 2'd0;
    assign req_ok   = (code_new == 2'd0);

    // Output-stage state register; async reset drops any pending word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_EMPTY;
        else        state <= state_next;
    end

    // Output-stage next state: start flushes, a legal accept loads, a completed write empties
    always_comb begin
        state_next = state;
        if (start)                                  state_next = ST_EMPTY;
        else if (accept && req_ok)                  state_next = ST_HOLD;
        else if (state == ST_HOLD && bus.wr_ready)  state_next = ST_EMPTY;
    end

    // Capture the encoded word, advance the write pointer/count, and latch the first error
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q   <= 32'd0;
            ptr      <= '0;
            word_cnt <= '0;
            err      <= 1'b0;
            err_code <= 2'd0;
        end else if (start) begin
            ptr      <= base_addr & ALIGN_MASK;
            word_cnt <= '0;
            err      <= 1'b0;
            err_code <= 2'd0;
        end else begin
            if (accept && req_ok) data_q <= enc_word;
            if (wr_fire) begin
                ptr      <= ptr + WORD_STEP;
                word_cnt <= word_cnt + CNT_W'(1);
            end
            if (accept && !req_ok && !err) begin
                err      <= 1'b1;
                err_code <= code_new;
            end
        end
    end
endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Sequential RV32I instruction encoder: inverse of the core's control decode.
- Accepts field-level requests (op, rd, rs1, rs2, imm) over valid/ready.
- Packs each request into a 32-bit machine word and streams it into instruction memory through a write handshake at auto-incrementing word addresses.
- Used by the testbench/loader path to program imem before the core is released.

Parameters:
- ADDR_W, 10, byte-address width of the imem write port.
- DEPTH, 256, capacity in words; must satisfy DEPTH*4 <= 2^ADDR_W.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  pulse: load base_addr, clear word count and errors.
- base_addr  in  ADDR_W  byte start address; bits [1:0] are ignored and forced to 0.
- req_valid  in  1  request valid.
- req_ready  out  1  request accepted when req_valid && req_ready.
- req_op  in  4  0 LW, 1 ADDI, 2 ORI, 3 ANDI, 4 ADD, 5 SUB, 6 OR, 7 AND, 8 SLT, 9 SW, 10 BEQ, 11 BNE, 12 JAL, 13 JALR; 14 and 15 are illegal.
- req_rd, req_rs1, req_rs2  in  5 each  register indices.
- req_imm  in  21  signed immediate, byte offset.
- wr_valid  out  1  imem write valid.
- wr_ready  in  1  imem accepts the write.
- wr_addr  out  ADDR_W  byte address.
- wr_data  out  32  encoded word.
- word_cnt  out  ADDR_W-1  words written since start.
- full  out  1  word_cnt == DEPTH.
- err  out  1  sticky error flag.
- err_code  out  2  1 illegal op, 2 imm out of range, 3 misaligned branch/jump offset.

Behaviour:
- Reset: all outputs 0 (req_ready 0 during reset); internal address pointer 0.
- Output stage is a one-entry register.
- req_ready = !full && (!wr_valid || wr_ready) && !start.
- Accept cycle: the encoded word is registered and wr_valid rises the next cycle. Latency is 1 clk from accept to wr_valid.
- wr_valid, wr_addr and wr_data hold stable until wr_valid && wr_ready.
- On each completed write: wr_addr += 4, wrapping modulo 2^ADDR_W, and word_cnt += 1.
- Accept and write-complete in the same cycle is legal; throughput is 1 word/clk.
- full asserts when word_cnt == DEPTH. req_ready then stays low until start.
- start: pointer <= {base_addr[ADDR_W-1:2],2'b00}; word_cnt, err and err_code clear; any pending wr_valid is dropped. start has priority over accept and over write-complete in the same cycle.
- Encodings (fields MSB to LSB):
  - LW: I-type, op 0000011, funct3 010.
  - ADDI / ORI / ANDI: op 0010011, funct3 000 / 110 / 111.
  - ADD / SUB / OR / AND / SLT: op 0110011, funct3 000 / 000 / 110 / 111 / 010; funct7 0100000 for SUB, else 0000000.
  - SW: S-type, op 0100011, funct3 010, {imm[11:5],rs2,rs1,f3,imm[4:0],op}.
  - BEQ / BNE: op 1100011, funct3 000 / 001, {imm[12],imm[10:5],rs2,rs1,f3,imm[4:1],imm[11],op}.
  - JAL: op 1101111, {imm[20],imm[10:1],imm[11],imm[19:12],rd,op}.
  - JALR: I-type, op 1100111, funct3 000.
  - Fields not used by a format are ignored.
- Range checks:
  - I/S types: imm must lie in -2048..2047.
  - B type: -4096..4094 and even.
  - J type: full 21-bit range and even.
  - R types: imm ignored.
- Illegal request: still accepted (handshake completes), produces no write, sets err, and latches err_code of the first error only.
- Checks are evaluated in the order illegal op, then range, then alignment; the first failing check sets err_code.
- Later legal requests continue normally while err is set.
- Async reset mid-write: wr_valid drops immediately; the word is lost.

Test Plan:
1. Reset, start base 0x000, ADDI rd1 rs1 0 imm 5, wr_ready=1 -> wr_valid at next clk, wr_addr 0x000, wr_data 0x00500093, word_cnt 1.
2. Back-to-back SUB x3,x1,x2; SW x2,8(x1); BEQ x1,x2,-4; JAL x1,+8 with wr_ready=1 -> data 0x402081B3, 0x0020A423, 0xFE208EE3, 0x008000EF at addrs 0,4,8,C, one per clk.
3. wr_ready held 0 for 3 clks during a stream -> req_ready low, wr_data/wr_addr stable; resumes with no loss or duplication.
4. ADDI imm 2048, then op 14, then BEQ imm 3 -> no writes, err=1, err_code=2 (first error); a following legal ADDI is still written at the next address.
5. DEPTH=4, base 0x3F8, ADDR_W=10 -> addrs 0x3F8, 0x3FC, 0x000, 0x004; then full=1, req_ready=0; start clears full and word_cnt.
6. Assert start in the same cycle as a pending write and an accepted request -> pending write dropped, request not accepted, pointer reloads base.
